// File: rtl/wb_ram_ff_pipe.sv
// wb_ram_ff_pipe: Wishbone B4 classic slave around a flip-flop RAM with
// byte-lane write masks and a 1..3 cycle registered read path.
// Optional feature macro: WB_RAM_FF_ERR_EN -- out-of-range accesses and
// writes with wb_sel_i == 0 terminate with wb_err_o instead of wb_ack_o.
//
// Handshake: a request is accepted on the rising edge where the FSM is IDLE
// and wb_cyc_i & wb_stb_i are high. It terminates with a single-cycle
// wb_ack_o (or wb_err_o) while the FSM sits in RESP and wb_cyc_i is still
// high; dropping wb_cyc_i before that aborts the transaction silently.
module wb_ram_ff_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic [31:0]             wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int ADR_LSB = $clog2(NB);
  localparam int AW      = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] pipe_q [3];
  logic [DATA_WIDTH-1:0] pipe_d [3];
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic [AW-1:0]         idx;
  logic [AW-1:0]         safe_idx;
  logic                  in_range;
  logic                  term_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [31:0]           unused_adr;

  // Address bits outside the word index are deliberately ignored.
  assign unused_adr = wb_adr_i;

  // Range check only exists when the depth is not a power of two.
  generate
    if ((1 << AW) == MEM_WORDS) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = ({1'b0, idx} < (AW+1)'(MEM_WORDS));
    end
  endgenerate

`ifdef WB_RAM_FF_ERR_EN
  assign term_err = !in_range || (wb_we_i && (wb_sel_i == '0));
`else
  assign term_err = 1'b0;
`endif

  // Decode word index, clamp it into the array and build the byte-merged write word.
  always_comb begin
    idx       = wb_adr_i[ADR_LSB +: AW];
    safe_idx  = in_range ? idx : '0;
    mem_rdata = mem_q[safe_idx];
    mem_wdata = mem_rdata;
    for (int b = 0; b < NB; b++) begin
      if (wb_sel_i[b]) mem_wdata[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  // Next-state logic: accept in IDLE, walk the read pipeline, terminate in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    err_d   = err_q;
    pipe_d  = pipe_q;
    hold_d  = hold_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          rd_d  = !wb_we_i;
          err_d = term_err;
          if (wb_we_i) begin
            mem_we  = in_range && (wb_sel_i != '0);
            state_d = RESP;
          end else begin
            pipe_d[0] = in_range ? mem_rdata : '0;
            if (READ_LATENCY == 1) begin
              state_d = RESP;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = 2'(READ_LATENCY - 1);
            end
          end
        end
      end
      RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          pipe_d[1] = pipe_q[0];
          pipe_d[2] = pipe_q[1];
          cnt_d     = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (wb_cyc_i && rd_q) hold_d = pipe_q[READ_LATENCY-1];
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and read-path registers; the array itself is not reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
      for (int i = 0; i < 3; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      for (int i = 0; i < 3; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Flip-flop RAM write port; the index is always in range here.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[safe_idx] <= mem_wdata;
  end

  // Termination pulses and read data; a dropped cyc suppresses both.
  always_comb begin
    wb_ack_o = (state_q == RESP) && wb_cyc_i && !err_q;
`ifdef WB_RAM_FF_ERR_EN
    wb_err_o = (state_q == RESP) && wb_cyc_i && err_q;
`else
    wb_err_o = 1'b0;
`endif
    wb_dat_o = ((state_q == RESP) && wb_cyc_i && rd_q) ? pipe_q[READ_LATENCY-1] : hold_q;
  end

endmodule

// File: tb/tb_wb_ram_ff_pipe.sv
// tb_wb_ram_ff_pipe: three DUT copies (read latency 1, 2, 3; 200 words)
// share address/data/sel/we; each has its own cyc/stb so single lanes can
// be exercised. Stimulus pushes expected terminations into per-lane queues,
// a negedge monitor pops and compares whenever ack or err is seen.
// Honours WB_RAM_FF_ERR_EN when defined for the build.
`timescale 1ns/1ps
module tb_wb_ram_ff_pipe;

  localparam int DW = 32;
  localparam int MW = 200;
  localparam int EW = 50;   // {is_err, is_rd, due[15:0], data[31:0]}
`ifdef WB_RAM_FF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we;
  logic [2:0]  cyc;
  logic [2:0]  stb;
  logic [2:0]  ack;
  logic [2:0]  err;
  logic [31:0] rdat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_ram_ff_pipe #(.DATA_WIDTH(DW), .MEM_WORDS(MW), .READ_LATENCY(g + 1)) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_ni (rst_n),
      .wb_adr_i  (adr),
      .wb_dat_i  (wdat),
      .wb_sel_i  (sel),
      .wb_we_i   (we),
      .wb_cyc_i  (cyc[g]),
      .wb_stb_i  (stb[g]),
      .wb_ack_o  (ack[g]),
      .wb_err_o  (err[g]),
      .wb_dat_o  (rdat[g])
    );
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rd [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic is_err, input logic is_rd,
                          input int unsigned due, input logic [31:0] d);
    logic [EW-1:0] e;
    e = {is_err, is_rd, due[15:0], d};
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic ok, output logic [EW-1:0] e);
    ok = 1'b0;
    e  = '0;
    case (k)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  logic          mon_ok;
  logic [EW-1:0] mon_e;
  logic [15:0]   mon_cyc;

  // monitor: sample on the falling edge, compare every termination seen
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ack[k] || err[k]) begin
          pop_exp(k, mon_ok, mon_e);
          if (!mon_ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL lane%0d_unexpected_term: got ack=%0b err=%0b required none (cycle %0d)",
                     k, ack[k], err[k], cycle_cnt);
          end else begin
            mon_cyc = cycle_cnt[15:0];
            check($sformatf("lane%0d_term_cycle", k), 64'(mon_cyc), 64'(mon_e[47:32]));
            check($sformatf("lane%0d_term_kind", k), 64'({ack[k], err[k]}),
                  mon_e[49] ? 64'd1 : 64'd2);
            if (mon_e[48] && !mon_e[49])
              check($sformatf("lane%0d_rd_data", k), 64'(rdat[k]), 64'(mon_e[31:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One transaction on the selected lanes: cyc&stb for the accept edge, then
  // stb low with cyc held until the slowest lane has terminated.
  task automatic bus_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] lanes,
                         input logic oor, input logic [31:0] exp_d);
    logic e_err;
    e_err = ERR_EN && (oor || (w && (s == 4'h0)));
    @(posedge clk); #1;
    adr = a; wdat = d; sel = s; we = w; cyc = lanes; stb = lanes;
    for (int k = 0; k < 3; k++) begin
      if (lanes[k]) begin
        push_exp(k, e_err, !w, cycle_cnt + (w ? 1 : k + 1), exp_d);
        if (!w && !e_err) last_rd[k] = exp_d;
      end
    end
    @(posedge clk); #1;
    stb = 3'b000;
    repeat (3) @(posedge clk);
    #1 cyc = 3'b000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic oor);
    bus_txn(1'b1, a, d, s, 3'b111, oor, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic oor);
    bus_txn(1'b0, a, 32'h0, 4'hF, 3'b111, oor, exp_d);
  endtask

  // Classic master: cyc and stb held for 8 edges; lane with latency L
  // re-accepts every L+1 cycles, transactions not finished before cyc drops abort.
  task automatic hold_read(input logic [31:0] a, input logic [31:0] exp_d);
    int unsigned c;
    @(posedge clk); #1;
    adr = a; we = 1'b0; sel = 4'hF; cyc = 3'b111; stb = 3'b111;
    c = cycle_cnt;
    for (int k = 0; k < 3; k++) begin
      for (int off = 0; off <= 7; off += k + 2) begin
        if (off + k + 1 <= 7) push_exp(k, 1'b0, 1'b1, c + off + k + 1, exp_d);
      end
      last_rd[k] = exp_d;
    end
    repeat (8) @(posedge clk);
    #1 cyc = 3'b000; stb = 3'b000;
    repeat (4) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = '0; stb = '0;
    for (int k = 0; k < 3; k++) last_rd[k] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lane%0d_reset_ack", k), 64'(ack[k]), 64'd0);
      check($sformatf("lane%0d_reset_err", k), 64'(err[k]), 64'd0);
      check($sformatf("lane%0d_reset_dat", k), 64'(rdat[k]), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;

    // byte-lane merge at word 4 (byte address 0x10)
    wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wr(32'h0000_0010, 32'h0000_00AA, 4'b0001, 1'b0);
    rd(32'h0000_0010, 32'hDEAD_BEAA, 1'b0);
    // ignored low/high address bits alias onto word 4 / word 8
    rd(32'hF000_0413, 32'hDEAD_BEAA, 1'b0);
    wr(32'h8000_0021, 32'h1234_5678, 4'hF, 1'b0);
    rd(32'h0000_0020, 32'h1234_5678, 1'b0);
    // upper half-word only, then a sel=0 write that changes nothing
    wr(32'h0000_0020, 32'hCAFE_0000, 4'b1100, 1'b0);
    rd(32'h0000_0020, 32'hCAFE_5678, 1'b0);
    wr(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd(32'h0000_0020, 32'hCAFE_5678, 1'b0);

    // range boundaries: word 0, last word 199, words 200 and 250 out of range
    wr(32'h0000_0000, 32'h1111_1111, 4'hF, 1'b0);
    wr(32'h0000_031C, 32'h0BAD_F00D, 4'hF, 1'b0);
    wr(32'h0000_03E8, 32'h5555_5555, 4'hF, 1'b1);
    rd(32'h0000_03E8, 32'h0000_0000, 1'b1);
    rd(32'h0000_0320, 32'h0000_0000, 1'b1);
    rd(32'h0000_031C, 32'h0BAD_F00D, 1'b0);
    rd(32'h0000_0000, 32'h1111_1111, 1'b0);

    // classic master holding stb through ack
    hold_read(32'h0000_0010, 32'hDEAD_BEAA);

    // abort: cyc dropped one cycle after accept on the latency-3 lane
    rd(32'h0000_0020, 32'hCAFE_5678, 1'b0);
    @(posedge clk); #1;
    adr = 32'h0000_0010; we = 1'b0; sel = 4'hF; cyc = 3'b100; stb = 3'b100;
    @(posedge clk); #1;
    cyc = 3'b000; stb = 3'b000;
    repeat (5) @(posedge clk);
    #1 check("abort_dat_hold", 64'(rdat[2]), 64'(last_rd[2]));

    // reset asserted while the latency-3 lane is in RD_WAIT
    @(posedge clk); #1;
    adr = 32'h0000_0010; we = 1'b0; sel = 4'hF; cyc = 3'b100; stb = 3'b100;
    @(posedge clk); #1;
    stb = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lane%0d_midreset_ack", k), 64'(ack[k]), 64'd0);
      check($sformatf("lane%0d_midreset_err", k), 64'(err[k]), 64'd0);
      check($sformatf("lane%0d_midreset_dat", k), 64'(rdat[k]), 64'd0);
      last_rd[k] = '0;
    end
    cyc = 3'b000;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    // array survives reset, next read terminates normally
    rd(32'h0000_0010, 32'hDEAD_BEAA, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("lane0_pending", 64'(exp_q0.size()), 64'd0);
    check("lane1_pending", 64'(exp_q1.size()), 64'd0);
    check("lane2_pending", 64'(exp_q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
